zorro3_burst_dma_master: RTL and testbench

//  Zorro III DMA bus-master cycle engine with multiple-transfer (burst) support, bus-error and timeout handling.

---
 rtl/zorro3_burst_dma_master.sv | 197 +++++++++++++++++++
 tb/tb_zorro3_burst_dma_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zorro3_burst_dma_master.sv
// Zorro III DMA bus-master cycle engine: turns SCSI-chip beat requests into
// FCS/DS/MTCR bus cycles with multiple-transfer bursts and BERR/timeout aborts.
module zorro3_burst_dma_master #(
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 1023,
  parameter int MULTI_EN  = 1
) (
  input  logic                           CLK,
  input  logic                           RESET_n,
  input  logic                           BMASTER,
  input  logic                           READ,
  input  logic [1:0]                     SIZ,
  input  logic [1:0]                     A,
  input  logic                           SCSI_AS_n,
  input  logic [$clog2(MAX_BURST+1)-1:0] BURST_LEN,
  input  logic                           ERR_CLR,
  input  logic                           ZORRO_FCS_n,
  input  logic                           ZORRO_DTACK_n,
  input  logic                           ZORRO_BERR_n,
  input  logic                           ZORRO_MTACK_n,
  output logic                           DMA_FCS_n,
  output logic [3:0]                     DMA_DS_n,
  output logic                           DMA_MTCR_n,
  output logic                           DMA_DOE,
  output logic                           SCSI_STERM_n,
  output logic                           BFCS_out,
  output logic                           BUSY,
  output logic                           ERR,
  output logic                           ABORT
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_TERM, S_NEXT, S_END, S_ERR
  } state_t;

  state_t        state_reg;
  logic          fcs_n_reg;
  logic [3:0]    ds_n_reg;
  logic          mtcr_n_reg;
  logic          sterm_n_reg;
  logic          err_reg;
  logic          abort_reg;
  logic          asq_reg;
  logic          mt_ok_reg;
  logic [BW-1:0] beats_reg;
  logic [TW-1:0] tmo_reg;

  logic [3:0]    size_n;
  logic [3:0]    lane_on;
  logic [3:0]    lanes_n;
  logic [BW-1:0] burst_clip;
  logic          tmo_hit;

  // Lanes run from byte 3-A downward for SIZ bytes, stopping at the longword edge.
  assign size_n = (SIZ == 2'b00) ? 4'd4 : {2'b00, SIZ};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_on[gi] = (({2'b00, A} + 4'(gi)) <= 4'd3) &&
                           (({2'b00, A} + size_n + 4'(gi)) >= 4'd4);
    end
  endgenerate

  assign lanes_n = READ ? 4'b0000 : ~lane_on;

  always_comb begin
    burst_clip = BURST_LEN;
    if (MULTI_EN == 0 || BURST_LEN == '0) burst_clip = BW'(1);
    else if (BURST_LEN > BURST_MAX)       burst_clip = BURST_MAX;
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_reg == TMO_LAST);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg   <= S_IDLE;
      fcs_n_reg   <= 1'b1;
      ds_n_reg    <= 4'b1111;
      mtcr_n_reg  <= 1'b1;
      sterm_n_reg <= 1'b1;
      err_reg     <= 1'b0;
      abort_reg   <= 1'b0;
      asq_reg     <= 1'b0;
      mt_ok_reg   <= 1'b0;
      beats_reg   <= '0;
      tmo_reg     <= '0;
    end else begin
      if (tmo_reg != '1) tmo_reg <= tmo_reg + 1'b1;
      if (!SCSI_AS_n) asq_reg <= 1'b1;
      if (ERR_CLR) begin
        err_reg   <= 1'b0;
        abort_reg <= 1'b0;
      end
      if (!BMASTER && (state_reg inside {S_ADDR, S_DATA, S_TERM, S_NEXT})) begin
        // Bus lost mid-cycle: drop every strobe at once and let END wait out DTACK.
        state_reg   <= S_END;
        tmo_reg     <= '0;
        fcs_n_reg   <= 1'b1;
        ds_n_reg    <= 4'b1111;
        mtcr_n_reg  <= 1'b1;
        sterm_n_reg <= 1'b1;
        mt_ok_reg   <= 1'b0;
        abort_reg   <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: if (BMASTER && asq_reg && ZORRO_DTACK_n && ZORRO_BERR_n) begin
            state_reg <= S_ADDR;
            tmo_reg   <= '0;
            asq_reg   <= 1'b0;
            fcs_n_reg <= 1'b0;
            beats_reg <= burst_clip;
            mt_ok_reg <= 1'b0;
          end
          S_ADDR: begin
            state_reg  <= S_DATA;
            tmo_reg    <= '0;
            ds_n_reg   <= lanes_n;
            mtcr_n_reg <= (beats_reg <= BW'(1));
          end
          S_DATA: begin
            if (!ZORRO_MTACK_n) mt_ok_reg <= 1'b1;
            if (!ZORRO_BERR_n || tmo_hit) begin
              state_reg  <= S_ERR;
              tmo_reg    <= '0;
              fcs_n_reg  <= 1'b1;
              ds_n_reg   <= 4'b1111;
              mtcr_n_reg <= 1'b1;
              err_reg    <= 1'b1;
            end else if (!ZORRO_DTACK_n) begin
              state_reg   <= S_TERM;
              tmo_reg     <= '0;
              ds_n_reg    <= 4'b1111;
              mtcr_n_reg  <= 1'b1;
              sterm_n_reg <= 1'b0;
            end else begin
              ds_n_reg <= lanes_n;
            end
          end
          S_TERM: begin
            sterm_n_reg <= 1'b1;
            beats_reg   <= beats_reg - 1'b1;
            tmo_reg     <= '0;
            // Without MTACK the slave cannot take more beats under this FCS.
            if (beats_reg == BW'(1) || !mt_ok_reg) begin
              state_reg <= S_END;
              fcs_n_reg <= 1'b1;
              mt_ok_reg <= 1'b0;
            end else begin
              state_reg <= S_NEXT;
            end
          end
          S_NEXT: begin
            if (asq_reg && ZORRO_DTACK_n) begin
              state_reg  <= S_DATA;
              tmo_reg    <= '0;
              asq_reg    <= 1'b0;
              ds_n_reg   <= lanes_n;
              mtcr_n_reg <= (beats_reg <= BW'(1));
            end else if (tmo_hit) begin
              state_reg <= S_END;
              tmo_reg   <= '0;
              fcs_n_reg <= 1'b1;
              mt_ok_reg <= 1'b0;
              abort_reg <= 1'b1;
            end
          end
          S_END: if (ZORRO_DTACK_n) begin
            state_reg <= S_IDLE;
            tmo_reg   <= '0;
          end
          S_ERR: if (ZORRO_DTACK_n && ZORRO_BERR_n) begin
            state_reg <= S_IDLE;
            tmo_reg   <= '0;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign DMA_FCS_n    = fcs_n_reg;
  assign DMA_DS_n     = ds_n_reg;
  assign DMA_MTCR_n   = mtcr_n_reg;
  assign SCSI_STERM_n = sterm_n_reg;
  assign DMA_DOE      = BMASTER && !READ;
  assign BFCS_out     = BMASTER ? ~fcs_n_reg : ~ZORRO_FCS_n;
  assign BUSY         = (state_reg != S_IDLE);
  assign ERR          = err_reg;
  assign ABORT        = abort_reg;

endmodule

// File: tb/tb_zorro3_burst_dma_master.sv
// Directed bench for zorro3_burst_dma_master: single, lane, burst, error,
// timeout, bus-loss and reset scenarios against a TIMEOUT=16 instance.
module tb_zorro3_burst_dma_master;

  logic       CLK = 1'b0;
  logic       RESET_n, BMASTER, READ, SCSI_AS_n, ERR_CLR;
  logic [1:0] SIZ, A;
  logic [3:0] BURST_LEN;
  logic       ZORRO_FCS_n, ZORRO_DTACK_n, ZORRO_BERR_n, ZORRO_MTACK_n;
  logic       DMA_FCS_n, DMA_MTCR_n, DMA_DOE, SCSI_STERM_n, BFCS_out, BUSY, ERR, ABORT;
  logic [3:0] DMA_DS_n;

  int tests_run = 0;
  int tests_failed = 0;
  int fcs_cnt, fcs_starts, sterm_cnt, ds_starts, ds_low_cnt, mtcr_low_cnt;
  logic [3:0] ds_first, mtcr_log, ds_prev;
  logic       fcs_prev;

  always #20 CLK = ~CLK;

  zorro3_burst_dma_master #(.MAX_BURST(8), .TIMEOUT(16), .MULTI_EN(1)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .BMASTER(BMASTER), .READ(READ), .SIZ(SIZ), .A(A),
    .SCSI_AS_n(SCSI_AS_n), .BURST_LEN(BURST_LEN), .ERR_CLR(ERR_CLR),
    .ZORRO_FCS_n(ZORRO_FCS_n), .ZORRO_DTACK_n(ZORRO_DTACK_n),
    .ZORRO_BERR_n(ZORRO_BERR_n), .ZORRO_MTACK_n(ZORRO_MTACK_n),
    .DMA_FCS_n(DMA_FCS_n), .DMA_DS_n(DMA_DS_n), .DMA_MTCR_n(DMA_MTCR_n),
    .DMA_DOE(DMA_DOE), .SCSI_STERM_n(SCSI_STERM_n), .BFCS_out(BFCS_out),
    .BUSY(BUSY), .ERR(ERR), .ABORT(ABORT)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  task automatic clear_stats();
    fcs_cnt = 0; fcs_starts = 0; sterm_cnt = 0; ds_starts = 0;
    ds_low_cnt = 0; mtcr_low_cnt = 0; ds_first = 4'b1111; mtcr_log = 4'b1111;
    fcs_prev = DMA_FCS_n; ds_prev = DMA_DS_n;
  endtask

  // Advance to the next falling edge and accumulate what the bus showed.
  task automatic cyc();
    @(negedge CLK);
    if (!DMA_FCS_n) fcs_cnt++;
    if (!DMA_FCS_n && fcs_prev) fcs_starts++;
    if (!SCSI_STERM_n) sterm_cnt++;
    if (!DMA_MTCR_n) mtcr_low_cnt++;
    if (DMA_DS_n !== 4'b1111) begin
      ds_low_cnt++;
      if (ds_prev === 4'b1111) begin
        if (ds_starts == 0) ds_first = DMA_DS_n;
        mtcr_log = {mtcr_log[2:0], DMA_MTCR_n};
        ds_starts++;
      end
    end
    fcs_prev = DMA_FCS_n;
    ds_prev  = DMA_DS_n;
  endtask

  task automatic pulse_as();
    SCSI_AS_n = 1'b0;
    cyc();
    SCSI_AS_n = 1'b1;
  endtask

  task automatic wait_ds(output bit ok);
    for (int i = 0; i < 40 && DMA_DS_n === 4'b1111; i++) cyc();
    ok = (DMA_DS_n !== 4'b1111);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL wait_ds: data strobes %b after 40 clk, expected asserted", DMA_DS_n); end
  endtask

  // Slave beat: DTACK goes low 'delay' cycles after DS appears, released on STERM.
  task automatic slave_beat(input int delay);
    bit ok;
    int n;
    wait_ds(ok);
    if (!ok) return;
    repeat (delay - 1) cyc();
    ZORRO_DTACK_n = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (SCSI_STERM_n && n < 10);
    ZORRO_DTACK_n = 1'b1;
    tests_run++;
    if (SCSI_STERM_n !== 1'b0) begin tests_failed++; $display("FAIL sterm_wait: STERM_n %b after DTACK, expected 0", SCSI_STERM_n); end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && BUSY !== 1'b0; i++) cyc();
    tests_run++;
    if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL wait_idle: BUSY %b after 60 clk, expected 0", BUSY); end
  endtask

  task automatic test_reset();
    repeat (2) cyc();
    tests_run++; if (DMA_FCS_n !== 1'b1) begin tests_failed++; $display("FAIL reset_fcs: got %b expected 1", DMA_FCS_n); end
    tests_run++; if (DMA_DS_n !== 4'b1111) begin tests_failed++; $display("FAIL reset_ds: got %b expected 1111", DMA_DS_n); end
    tests_run++; if ({DMA_MTCR_n, SCSI_STERM_n} !== 2'b11) begin tests_failed++; $display("FAIL reset_mtcr_sterm: got %b expected 11", {DMA_MTCR_n, SCSI_STERM_n}); end
    tests_run++; if ({BUSY, ERR, ABORT} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 000", {BUSY, ERR, ABORT}); end
    ZORRO_FCS_n = 1'b0;
    #1;
    tests_run++; if (BFCS_out !== 1'b1) begin tests_failed++; $display("FAIL bfcs_passthru: got %b expected 1", BFCS_out); end
    ZORRO_FCS_n = 1'b1;
    RESET_n = 1'b1;
    BMASTER = 1'b1;
    cyc();
    tests_run++; if (DMA_DOE !== 1'b1) begin tests_failed++; $display("FAIL doe_write: got %b expected 1", DMA_DOE); end
    tests_run++; if (BFCS_out !== 1'b0) begin tests_failed++; $display("FAIL bfcs_own_idle: got %b expected 0", BFCS_out); end
    $display("[TB] reset: fcs=%b ds=%b busy=%b", DMA_FCS_n, DMA_DS_n, BUSY);
  endtask

  task automatic test_single_write();
    READ = 1'b0; SIZ = 2'b00; A = 2'b00; BURST_LEN = 4'd1;
    clear_stats();
    pulse_as();
    slave_beat(3);
    wait_idle();
    tests_run++; if (fcs_cnt != 5) begin tests_failed++; $display("FAIL single_fcs_len: got %0d expected 5", fcs_cnt); end
    tests_run++; if (sterm_cnt != 1) begin tests_failed++; $display("FAIL single_sterm: got %0d expected 1", sterm_cnt); end
    tests_run++; if (ds_first !== 4'b0000) begin tests_failed++; $display("FAIL single_ds: got %b expected 0000", ds_first); end
    tests_run++; if (mtcr_low_cnt != 0) begin tests_failed++; $display("FAIL single_mtcr: got %0d low cycles expected 0", mtcr_low_cnt); end
    tests_run++; if (ERR !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", ERR); end
    $display("[TB] single write: fcs_low=%0d sterm=%0d ds=%b", fcs_cnt, sterm_cnt, ds_first);
  endtask

  task automatic test_lanes();
    logic [8:0] vec [7];
    logic [3:0] exp_ds;
    vec[0] = 9'b0_01_11_1110; vec[1] = 9'b0_10_01_1001; vec[2] = 9'b1_00_00_0000;
    vec[3] = 9'b0_01_00_0111; vec[4] = 9'b0_11_01_1000; vec[5] = 9'b0_10_11_1110;
    vec[6] = 9'b0_00_10_1100;
    for (int v = 0; v < 7; v++) begin
      READ = vec[v][8]; SIZ = vec[v][7:6]; A = vec[v][5:4]; exp_ds = vec[v][3:0];
      BURST_LEN = 4'd1;
      clear_stats();
      pulse_as();
      tests_run++; if (DMA_DOE !== !vec[v][8]) begin tests_failed++; $display("FAIL lane_doe[%0d]: got %b expected %b", v, DMA_DOE, !vec[v][8]); end
      slave_beat(1);
      wait_idle();
      tests_run++; if (ds_first !== exp_ds) begin tests_failed++; $display("FAIL lane_ds[%0d]: got %b expected %b", v, ds_first, exp_ds); end
      $display("[TB] lanes read=%b siz=%b a=%b: ds=%b", READ, SIZ, A, ds_first);
    end
    READ = 1'b0; SIZ = 2'b00; A = 2'b00;
  endtask

  task automatic test_burst();
    BURST_LEN = 4'd4; ZORRO_MTACK_n = 1'b0;
    clear_stats();
    pulse_as();
    for (int b = 0; b < 4; b++) begin
      slave_beat(2);
      if (b < 3) pulse_as();
    end
    wait_idle();
    ZORRO_MTACK_n = 1'b1;
    tests_run++; if (fcs_starts != 1) begin tests_failed++; $display("FAIL burst_fcs_count: got %0d expected 1", fcs_starts); end
    tests_run++; if (sterm_cnt != 4) begin tests_failed++; $display("FAIL burst_sterm: got %0d expected 4", sterm_cnt); end
    tests_run++; if (ds_starts != 4) begin tests_failed++; $display("FAIL burst_beats: got %0d expected 4", ds_starts); end
    tests_run++; if (mtcr_log !== 4'b0001) begin tests_failed++; $display("FAIL burst_mtcr: got %b expected 0001", mtcr_log); end
    $display("[TB] burst x4: fcs=%0d sterm=%0d mtcr=%b", fcs_starts, sterm_cnt, mtcr_log);
  endtask

  task automatic test_burst_no_mtack();
    BURST_LEN = 4'd4; ZORRO_MTACK_n = 1'b1;
    clear_stats();
    pulse_as();
    slave_beat(1);
    pulse_as();
    slave_beat(1);
    wait_idle();
    tests_run++; if (fcs_starts != 2) begin tests_failed++; $display("FAIL nomt_fcs_count: got %0d expected 2", fcs_starts); end
    tests_run++; if (sterm_cnt != 2) begin tests_failed++; $display("FAIL nomt_sterm: got %0d expected 2", sterm_cnt); end
    tests_run++; if (mtcr_log[1:0] !== 2'b00) begin tests_failed++; $display("FAIL nomt_mtcr: got %b expected 00", mtcr_log[1:0]); end
    $display("[TB] burst no mtack: fcs=%0d sterm=%0d", fcs_starts, sterm_cnt);
  endtask

  task automatic test_burst_len_zero();
    BURST_LEN = 4'd0; ZORRO_MTACK_n = 1'b0;
    clear_stats();
    pulse_as();
    slave_beat(1);
    wait_idle();
    ZORRO_MTACK_n = 1'b1;
    tests_run++; if (mtcr_low_cnt != 0) begin tests_failed++; $display("FAIL len0_mtcr: got %0d low cycles expected 0", mtcr_low_cnt); end
    tests_run++; if (fcs_starts != 1 || sterm_cnt != 1) begin tests_failed++; $display("FAIL len0_cycle: got fcs=%0d sterm=%0d expected 1/1", fcs_starts, sterm_cnt); end
    $display("[TB] burst_len 0: mtcr_low=%0d sterm=%0d", mtcr_low_cnt, sterm_cnt);
  endtask

  task automatic test_berr();
    bit ok;
    BURST_LEN = 4'd1;
    clear_stats();
    pulse_as();
    wait_ds(ok);
    ZORRO_DTACK_n = 1'b0; ZORRO_BERR_n = 1'b0;
    cyc();
    tests_run++; if (ERR !== 1'b1) begin tests_failed++; $display("FAIL berr_err: got %b expected 1", ERR); end
    tests_run++; if (DMA_FCS_n !== 1'b1) begin tests_failed++; $display("FAIL berr_fcs: got %b expected 1", DMA_FCS_n); end
    cyc();
    ZORRO_DTACK_n = 1'b1; ZORRO_BERR_n = 1'b1;
    wait_idle();
    tests_run++; if (sterm_cnt != 0) begin tests_failed++; $display("FAIL berr_sterm: got %0d expected 0", sterm_cnt); end
    tests_run++; if (ERR !== 1'b1) begin tests_failed++; $display("FAIL berr_sticky: got %b expected 1", ERR); end
    ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
    tests_run++; if (ERR !== 1'b0) begin tests_failed++; $display("FAIL berr_clear: got %b expected 0", ERR); end
    $display("[TB] berr: sterm=%0d err_after_clr=%b", sterm_cnt, ERR);
  endtask

  task automatic test_timeout();
    bit ok;
    BURST_LEN = 4'd1;
    clear_stats();
    pulse_as();
    wait_ds(ok);
    for (int i = 0; i < 40 && DMA_DS_n !== 4'b1111; i++) cyc();
    tests_run++; if (ds_low_cnt != 16) begin tests_failed++; $display("FAIL timeout_len: got %0d data cycles expected 16", ds_low_cnt); end
    tests_run++; if (ERR !== 1'b1) begin tests_failed++; $display("FAIL timeout_err: got %b expected 1", ERR); end
    wait_idle();
    tests_run++; if (sterm_cnt != 0) begin tests_failed++; $display("FAIL timeout_sterm: got %0d expected 0", sterm_cnt); end
    ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
    $display("[TB] timeout: data_cycles=%0d", ds_low_cnt);
  endtask

  task automatic test_abort_next();
    BURST_LEN = 4'd4; ZORRO_MTACK_n = 1'b0;
    clear_stats();
    pulse_as();
    slave_beat(1);
    cyc();
    tests_run++; if (DMA_FCS_n !== 1'b0) begin tests_failed++; $display("FAIL next_fcs_held: got %b expected 0", DMA_FCS_n); end
    BMASTER = 1'b0;
    cyc();
    tests_run++; if (DMA_FCS_n !== 1'b1) begin tests_failed++; $display("FAIL abort_fcs: got %b expected 1", DMA_FCS_n); end
    tests_run++; if ({ABORT, ERR} !== 2'b10) begin tests_failed++; $display("FAIL abort_flags: got %b expected 10", {ABORT, ERR}); end
    wait_idle();
    tests_run++; if (sterm_cnt != 1) begin tests_failed++; $display("FAIL abort_sterm: got %0d expected 1", sterm_cnt); end
    BMASTER = 1'b1; ZORRO_MTACK_n = 1'b1;
    ERR_CLR = 1'b1; cyc(); ERR_CLR = 1'b0;
    tests_run++; if (ABORT !== 1'b0) begin tests_failed++; $display("FAIL abort_clear: got %b expected 0", ABORT); end
    $display("[TB] abort in NEXT: sterm=%0d abort_after_clr=%b", sterm_cnt, ABORT);
  endtask

  task automatic test_reset_mid();
    BURST_LEN = 4'd1;
    clear_stats();
    pulse_as();
    cyc();
    cyc();
    tests_run++; if (DMA_DS_n !== 4'b0000) begin tests_failed++; $display("FAIL mid_pre_ds: got %b expected 0000", DMA_DS_n); end
    #5 RESET_n = 1'b0;
    #1;
    tests_run++; if ({DMA_FCS_n, DMA_DS_n} !== 5'b11111) begin tests_failed++; $display("FAIL mid_reset_strobes: got %b expected 11111", {DMA_FCS_n, DMA_DS_n}); end
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b expected 0", BUSY); end
    @(negedge CLK);
    RESET_n = 1'b1;
    repeat (3) cyc();
    tests_run++; if (BUSY !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_stays_idle: got %b expected 0", BUSY); end
    $display("[TB] reset mid-cycle: fcs=%b busy=%b", DMA_FCS_n, BUSY);
  endtask

  initial begin
    RESET_n = 1'b0; BMASTER = 1'b0; READ = 1'b0; SIZ = 2'b00; A = 2'b00;
    SCSI_AS_n = 1'b1; BURST_LEN = 4'd1; ERR_CLR = 1'b0;
    ZORRO_FCS_n = 1'b1; ZORRO_DTACK_n = 1'b1; ZORRO_BERR_n = 1'b1; ZORRO_MTACK_n = 1'b1;
    test_reset();
    test_single_write();
    test_lanes();
    test_burst();
    test_burst_no_mtack();
    test_burst_len_zero();
    test_berr();
    test_timeout();
    test_abort_next();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
